// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Entry layout below is sized for the default 32-bit / 16-entry geometry.
package branch_predictor_pkg;

    localparam int BP_IDX_W = 4;
    localparam int BP_XLEN  = 32;
    localparam int BP_TAG_W = BP_XLEN - BP_IDX_W - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST = WNT;

    typedef struct packed {
        logic                valid;
        ctr_e                ctr;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and execute resolve signals between the pipeline (master) and predictor (slave).
interface branch_predictor_if #(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
);
    logic [XLEN-1:0]  f_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [IDX_W-1:0] pred_idx;

    logic             ex_valid;
    logic             ex_is_branch;
    logic [XLEN-1:0]  ex_pc;
    logic [IDX_W-1:0] ex_idx;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;

    modport master (
        output f_pc, ex_valid, ex_is_branch, ex_pc, ex_idx, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, pred_idx, mispredict, redirect_pc
    );

    modport slave (
        input  f_pc, ex_valid, ex_is_branch, ex_pc, ex_idx, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, pred_idx, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state; allocation forces weakly-taken.
// Purely combinational.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    input  logic i_alloc,
    output ctr_e o_ctr
);
    logic [1:0] w_cur;

    assign w_cur = i_ctr;

    always_comb begin
        o_ctr = i_ctr;
        if (i_alloc) begin
            o_ctr = WT;
        end else if (i_taken) begin
            if (i_ctr != ST) begin
                o_ctr = ctr_e'(w_cur + 2'b01);
            end
        end else if (i_ctr != SNT) begin
            o_ctr = ctr_e'(w_cur - 2'b01);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor + BTB with combinational lookup and resolve-time training.
// Define BP_GSHARE_EN to XOR a non-speculative global history into the index.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int XLEN  = BP_XLEN
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_if.slave   bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = XLEN - IDX_W - 2;

    btb_entry_t       r_tab [DEPTH];

    logic [IDX_W-1:0] w_base_idx;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_lookup_tag;
    logic             w_hit;
    logic             w_resolve;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_realloc;
    ctr_e             w_next_ctr;
    logic             w_unused_pc_lsb;

    assign w_base_idx      = bp.f_pc[IDX_W+1:2];
    assign w_lookup_tag    = bp.f_pc[XLEN-1:IDX_W+2];
    assign w_unused_pc_lsb = &{1'b0, bp.f_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    assign w_idx = w_base_idx ^ r_ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_resolve) begin
            r_ghr <= {r_ghr[IDX_W-2:0], bp.ex_taken};
        end
    end
`else
    assign w_idx = w_base_idx;
`endif

    // No bypass: a same-cycle update is only visible after the edge.
    assign w_hit          = r_tab[w_idx].valid && (r_tab[w_idx].tag == w_lookup_tag);
    assign bp.pred_taken  = w_hit & r_tab[w_idx].ctr[1];
    assign bp.pred_target = r_tab[w_idx].target;
    assign bp.pred_idx    = w_idx;

    assign w_resolve = bp.ex_valid & bp.ex_is_branch;
    assign w_ex_tag  = bp.ex_pc[XLEN-1:IDX_W+2];

    // An invalid slot holds a meaningless tag, so it is treated as a miss too.
    assign w_realloc = bp.ex_taken &
                       (!r_tab[bp.ex_idx].valid || (r_tab[bp.ex_idx].tag != w_ex_tag));

    sat_counter2 u_sat_counter2 (
        .i_ctr   (r_tab[bp.ex_idx].ctr),
        .i_taken (bp.ex_taken),
        .i_alloc (w_realloc),
        .o_ctr   (w_next_ctr)
    );

    assign bp.mispredict  = w_resolve &
                            ((bp.ex_pred_taken != bp.ex_taken) |
                             (bp.ex_taken & (bp.ex_pred_target != bp.ex_target)));
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : (bp.ex_pc + XLEN'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab[i].valid  <= 1'b0;
                r_tab[i].ctr    <= CTR_RST;
                r_tab[i].tag    <= '0;
                r_tab[i].target <= '0;
            end
        end else if (w_resolve) begin
            r_tab[bp.ex_idx].ctr <= w_next_ctr;
            if (bp.ex_taken) begin
                r_tab[bp.ex_idx].valid  <= 1'b1;
                r_tab[bp.ex_idx].tag    <= w_ex_tag;
                r_tab[bp.ex_idx].target <= bp.ex_target;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (IDX_W=4, XLEN=32); 0x40 and 0x440 both map to index 0.
module tb_branch_predictor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    branch_predictor_if #(.IDX_W(4), .XLEN(32)) bp_if_i ();

    branch_predictor #(.IDX_W(4), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [3:0] idx, input logic taken,
                           input logic [31:0] target, input logic ptaken,
                           input logic [31:0] ptarget);
        bp_if_i.ex_valid       = 1'b1;
        bp_if_i.ex_is_branch   = 1'b1;
        bp_if_i.ex_pc          = pc;
        bp_if_i.ex_idx         = idx;
        bp_if_i.ex_taken       = taken;
        bp_if_i.ex_target      = target;
        bp_if_i.ex_pred_taken  = ptaken;
        bp_if_i.ex_pred_target = ptarget;
        #1;
    endtask

    task automatic idle();
        bp_if_i.ex_valid     = 1'b0;
        bp_if_i.ex_is_branch = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bp_if_i.f_pc = pc;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bp_if_i.f_pc = 32'h0;
        idle();
        bp_if_i.ex_pc = 32'h0;
        bp_if_i.ex_idx = 4'h0;
        bp_if_i.ex_taken = 1'b0;
        bp_if_i.ex_target = 32'h0;
        bp_if_i.ex_pred_taken = 1'b0;
        bp_if_i.ex_pred_target = 32'h0;

        tick();
        fetch(32'h40);
        chk("rst_pred_taken", bp_if_i.pred_taken, 0);
        chk("rst_mispredict_idle", bp_if_i.mispredict, 0);
        tick();
        rst = 1'b0;

        // Training: first taken resolve allocates the entry
        resolve(32'h40, 4'h0, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("train_mispredict", bp_if_i.mispredict, 1);
        chk("train_redirect", bp_if_i.redirect_pc, 32'h80);
        tick();
        idle();
        fetch(32'h40);
        chk("train_pred_taken", bp_if_i.pred_taken, 1);
        chk("train_pred_target", bp_if_i.pred_target, 32'h80);
        chk("train_pred_idx", bp_if_i.pred_idx, 0);

        resolve(32'h40, 4'h0, 1'b0, 32'h80, 1'b1, 32'h80);
        chk("nt1_mispredict", bp_if_i.mispredict, 1);
        chk("nt1_redirect", bp_if_i.redirect_pc, 32'h44);
        tick();
        resolve(32'h40, 4'h0, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        idle();
        fetch(32'h40);
        chk("nt2_pred_taken", bp_if_i.pred_taken, 0);
        chk("nt2_target_kept", bp_if_i.pred_target, 32'h80);

        // Saturation: 00 -> 01,10,11,11,11 then N -> 10
        for (int i = 0; i < 5; i++) begin
            resolve(32'h40, 4'h0, 1'b1, 32'h80, 1'b0, 32'h80);
            tick();
        end
        resolve(32'h40, 4'h0, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        idle();
        fetch(32'h40);
        chk("sat_pred_taken", bp_if_i.pred_taken, 1);

        // Target mismatch on a correctly predicted direction
        resolve(32'h40, 4'h0, 1'b1, 32'h90, 1'b1, 32'h80);
        chk("tgt_mispredict", bp_if_i.mispredict, 1);
        chk("tgt_redirect", bp_if_i.redirect_pc, 32'h90);
        tick();
        idle();
        fetch(32'h40);
        chk("tgt_pred_target", bp_if_i.pred_target, 32'h90);
        chk("tgt_pred_taken", bp_if_i.pred_taken, 1);

        resolve(32'h40, 4'h0, 1'b1, 32'h90, 1'b1, 32'h90);
        chk("correct_no_mispredict", bp_if_i.mispredict, 0);
        tick();

        // Non-branch and invalid slots leave the table alone
        resolve(32'h40, 4'h0, 1'b0, 32'h0, 1'b1, 32'h90);
        bp_if_i.ex_is_branch = 1'b0;
        #1;
        chk("nonbranch_mispredict", bp_if_i.mispredict, 0);
        tick();
        bp_if_i.ex_is_branch = 1'b1;
        bp_if_i.ex_valid = 1'b0;
        #1;
        chk("invalid_mispredict", bp_if_i.mispredict, 0);
        tick();
        idle();
        fetch(32'h40);
        chk("nonbranch_untouched", bp_if_i.pred_taken, 1);

        // Aliasing: 0x440 evicts 0x40 and reallocates with counter 10
        resolve(32'h440, 4'h0, 1'b1, 32'h200, 1'b0, 32'h0);
        chk("alias_mispredict", bp_if_i.mispredict, 1);
        tick();
        idle();
        fetch(32'h40);
        chk("alias_evicted", bp_if_i.pred_taken, 0);
        fetch(32'h440);
        chk("alias_new_taken", bp_if_i.pred_taken, 1);
        chk("alias_new_target", bp_if_i.pred_target, 32'h200);
        resolve(32'h440, 4'h0, 1'b0, 32'h200, 1'b1, 32'h200);
        tick();
        idle();
        fetch(32'h440);
        chk("realloc_ctr_is_10", bp_if_i.pred_taken, 0);

        // Same-cycle lookup and update: pre-update contents visible
        fetch(32'h440);
        resolve(32'h440, 4'h0, 1'b1, 32'h300, 1'b0, 32'h200);
        chk("hazard_old_taken", bp_if_i.pred_taken, 0);
        chk("hazard_old_target", bp_if_i.pred_target, 32'h200);
        tick();
        idle();
        #1;
        chk("hazard_new_taken", bp_if_i.pred_taken, 1);
        chk("hazard_new_target", bp_if_i.pred_target, 32'h300);

        // Fall-through PC wraps to zero
        resolve(32'hFFFF_FFFC, 4'hF, 1'b0, 32'h0, 1'b1, 32'h1234);
        chk("wrap_mispredict", bp_if_i.mispredict, 1);
        chk("wrap_redirect", bp_if_i.redirect_pc, 32'h0);
        tick();
        idle();

        // Mid-run reset clears immediately and drops a coinciding update
        fetch(32'h440);
        chk("pre_reset_taken", bp_if_i.pred_taken, 1);
        resolve(32'h440, 4'h0, 1'b1, 32'h300, 1'b1, 32'h300);
        rst = 1'b1;
        #1;
        chk("async_reset_taken", bp_if_i.pred_taken, 0);
        tick();
        idle();
        rst = 1'b0;
        fetch(32'h440);
        chk("dropped_update", bp_if_i.pred_taken, 0);
        resolve(32'h500, 4'h0, 1'b1, 32'h100, 1'b0, 32'h0);
        chk("post_reset_mispredict", bp_if_i.mispredict, 1);
        chk("post_reset_redirect", bp_if_i.redirect_pc, 32'h100);
        idle();
        #1;

        // History after T,T,N from reset, seen as the index of PC 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resolve(32'h0, 4'h0, 1'b1, 32'h8, 1'b0, 32'h0);
        tick();
        resolve(32'h0, 4'h0, 1'b1, 32'h8, 1'b0, 32'h0);
        tick();
        resolve(32'h0, 4'h0, 1'b0, 32'h8, 1'b0, 32'h0);
        tick();
        idle();
        fetch(32'h0);
`ifdef BP_GSHARE_EN
        chk("ghr_ttn", bp_if_i.pred_idx, 32'h6);
`else
        chk("idx_no_history", bp_if_i.pred_idx, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor that pairs with the execute-stage branch comparator. It supplies a taken/not-taken guess and a target for the PC being fetched. When the execute stage later resolves the branch outcome (`ex_taken`), the block trains a table of 2-bit saturating counters and a branch target buffer (BTB). It flags mispredictions and produces the corrected fetch PC.

## Interface
Parameters:
- `IDX_W`, 4: index width; the table holds 2^IDX_W entries.
- `XLEN`, 32: address width.

Ports:
- `clk`  in  1  clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `f_pc`  in  XLEN  PC currently being fetched.
- `pred_taken`  out  1  prediction for `f_pc`.
- `pred_target`  out  XLEN  predicted target; meaningful only when `pred_taken`=1.
- `pred_idx`  out  IDX_W  table index used for this prediction; the pipeline carries it to execute.
- `ex_valid`  in  1  execute stage holds a valid instruction.
- `ex_is_branch`  in  1  that instruction is a conditional branch.
- `ex_pc`  in  XLEN  PC of the resolving instruction.
- `ex_idx`  in  IDX_W  `pred_idx` carried from fetch.
- `ex_taken`  in  1  resolved outcome (BA from the comparator).
- `ex_target`  in  XLEN  resolved branch target.
- `ex_pred_taken`  in  1  prediction made at fetch, carried down the pipe.
- `ex_pred_target`  in  XLEN  predicted target, carried down the pipe.
- `mispredict`  out  1  flush request.
- `redirect_pc`  out  XLEN  correct next PC; valid when `mispredict`=1.

## Operation
- Each entry holds `ctr[1:0]`, `valid`, `tag[XLEN-IDX_W-3:0]` and `target[XLEN-1:0]`.
- Lookup tag = `f_pc[XLEN-1:IDX_W+2]`. Base index = `f_pc[IDX_W+1:2]`.
- Hit = `valid[idx]` and the stored tag equals the lookup tag.
- `pred_taken` = hit & `ctr[idx][1]`. `pred_target` = `target[idx]`.
- Resolve event = `ex_valid & ex_is_branch`. Non-branches and invalid slots never touch the tables.
- On a resolve event, the entry at `ex_idx` is updated as follows:
  - The counter increments when taken and decrements when not taken.
  - The counter saturates at 2'b11 and 2'b00.
  - When taken: `valid`=1, `tag` from `ex_pc`, `target`=`ex_target`.
  - When not taken: tag, target and valid are left unchanged.
- Tag mismatch on a taken update: the entry is reallocated and its counter is written to 2'b10, not incremented.
- `mispredict` = resolve event & ((`ex_pred_taken` != `ex_taken`) | (`ex_taken` & `ex_pred_target` != `ex_target`)).
- `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc` + 4, with the sum truncated to XLEN (wraps past 0xFFFFFFFC to 0).
- Same-cycle read and write to the same index: the lookup returns the pre-update contents. There is no bypass.

## Timing
- Lookup is combinational from `f_pc`; prediction has zero latency.
- `mispredict` and `redirect_pc` are combinational from the ex inputs, in the same cycle as resolve.
- Table and history writes take effect at the rising `clk` edge following the resolve event.
- Reset values:
  - All `ctr` = 2'b01 (weakly not taken), all `valid` = 0, GHR = 0.
  - As a result, `pred_taken`=0 for every PC, and `mispredict`=0 while `ex_valid`=0.
- Reset asserted mid-operation clears the state immediately. An update coinciding with reset is dropped.
- `pred_target` and `redirect_pc` carry no reset requirement when their qualifiers are low.

## Configuration
- `BP_GSHARE_EN` defined:
  - An IDX_W-bit global history register (GHR) is added.
  - Lookup index = base index XOR GHR.
  - On each resolve event, GHR <= {GHR[IDX_W-2:0], `ex_taken`} at the clock edge. History is non-speculative and updated at resolve only.
- `BP_GSHARE_EN` undefined: no GHR; index = base index. `pred_idx`/`ex_idx` are still used unchanged, so the port list is identical in both builds.

## Structure
- Shared package:
  - Counter encodings `SNT`=00, `WNT`=01, `WT`=10, `ST`=11.
  - The reset counter value.
  - The default `IDX_W`.
  - A typedef for the BTB entry struct.
- One natural sub-module: `sat_counter2`, the 2-bit saturating next-state function, instantiated for the update path.
- Tables are flop arrays with asynchronous clear, not RAM, because lookup is combinational.

## Test plan
- **Reset:** assert `rst` mid-run, then fetch any `f_pc` -> `pred_taken`=0; an ex branch taken to 0x100 -> `mispredict`=1, `redirect_pc`=0x100.
- **Training:**
  - Resolve `ex_pc`=0x40 taken to 0x80 with `ex_pred_taken`=0 -> next cycle `f_pc`=0x40 gives `pred_taken`=1, `pred_target`=0x80.
  - Then two not-taken resolves -> `pred_taken`=0.
- **Saturation:** five taken resolves at 0x40, then one not-taken -> the counter is 10 and the entry still predicts taken.
- **Target mismatch:** `ex_pred_taken`=1, `ex_taken`=1, `ex_pred_target`=0x80, `ex_target`=0x90 -> `mispredict`=1, `redirect_pc`=0x90, and the BTB target becomes 0x90.
- **Aliasing and hazard:**
  - 0x40 and 0x440 with IDX_W=4 share an index; a taken update for 0x440 evicts 0x40, so fetching 0x40 gives `pred_taken`=0.
  - Same-cycle lookup and update on one index -> the old value is returned.
- **Not taken and wrap:** `ex_pc`=0xFFFFFFFC not taken, mispredicted -> `redirect_pc`=0x0. With `BP_GSHARE_EN`, after resolves T,T,N the GHR = 4'b0110.
